controlador_temporizador_32: RTL and testbench
==============================================

CONTROLADOR_TEMPORIZADOR_32 -- requirements
Module: controlador_temporizador_32

Interface
REQ-001 Parameter PRE_W, default 16: prescaler width in bits (1..32).
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  start/restart request, sampled every cycle.
REQ-005 stop  input  1  stop request; has priority over start.
REQ-006 hold  input  1  freeze prescaler and count ticks while in RUN.
REQ-007 mode  input  1  1 = periodic, 0 = one-shot; latched on start.
REQ-008 dir  input  1  1 = count up, 0 = count down; latched on start.
REQ-009 reload  input  32  counter preload value; latched on start.
REQ-010 presc  input  PRE_W  tick divider (tick every presc+1 RUN cycles); latched on start.
REQ-011 irq_clr  input  1  clears irq and ovr.
REQ-012 cnt_tc  input  1  terminal count from the downstream 32-bit up/down counter (ena-qualified).
REQ-013 cnt_ena  output  1  counter enable.
REQ-014 cnt_load  output  1  counter load strobe.
REQ-015 cnt_up  output  1  counter direction (= latched dir).
REQ-016 cnt_d  output  32  counter load data (= latched reload).
REQ-017 busy  output  1  high in LOAD or RUN.
REQ-018 ev  output  1  one-cycle pulse, one cycle after each expiry.
REQ-019 irq  output  1  sticky expiry flag.
REQ-020 ovr  output  1  sticky flag: expiry occurred while irq already set.

Function
REQ-021 FSM states IDLE, LOAD, RUN; registered state, outputs decoded from state and prescaler registers.
REQ-022 Any state, stop=1: next state IDLE; shadow registers unchanged.
REQ-023 Any state, start=1 and stop=0: latch mode, dir, reload, presc into shadows; next state LOAD (restart from RUN or LOAD allowed).
REQ-024 LOAD: cnt_ena=1, cnt_load=1, prescaler counter cleared to 0; next state RUN unless REQ-022/023 apply.
REQ-025 RUN, hold=0: prescaler increments; when prescaler == presc shadow, tick=1 and prescaler returns to 0; presc=0 gives tick every cycle.
REQ-026 RUN: cnt_ena = tick & ~hold; cnt_load=0; hold=1 freezes prescaler, cnt_ena=0.
REQ-027 Expiry = RUN & tick & ~hold & cnt_tc.
REQ-028 On expiry, periodic: next state LOAD (counter reloaded, one-cycle gap); one-shot: next state IDLE.
REQ-029 stop in the expiry cycle: IDLE, expiry still reported; start in the expiry cycle: restart wins over REQ-028, expiry still reported.
REQ-030 On expiry: ev=1 next cycle only; irq set next cycle; if irq already 1, ovr set next cycle.
REQ-031 irq_clr=1 clears irq and ovr next cycle; simultaneous expiry wins (irq=1, ovr=0).
REQ-032 IDLE: cnt_ena=0, cnt_load=0; counter value held.
REQ-033 cnt_up and cnt_d reflect shadow dir/reload in all states.
REQ-034 Prescaler compare is PRE_W-bit unsigned; no overflow possible since presc <= 2^PRE_W-1.

Reset
REQ-035 rst=1: state IDLE, prescaler 0, reload shadow 0, presc shadow 0, mode shadow 0, dir shadow 1, ev=0, irq=0, ovr=0; hence cnt_ena=0, cnt_load=0, cnt_up=1, cnt_d=0, busy=0 the cycle after.
REQ-036 rst has priority over start, stop, irq_clr and expiry; reset mid-RUN aborts without ev.

Verification (bench pairs block with the counter, FROM=0, TO=9)
REQ-037 Periodic up, reload=7, presc=0, start pulse at cycle 0 -> LOAD cycle 1, cnt = 7,8,9 on cycles 2..4, expiry cycle 4, ev cycles 5, 9, 13 (period 4), irq=1 from cycle 5.
REQ-038 One-shot down, reload=2, presc=2 -> cnt_ena high every 3rd RUN cycle, cnt 2,1,0, expiry on tick with cnt=0, single ev, busy=0 after, cnt stays 9 (wrapped).
REQ-039 hold=1 for 5 cycles mid-RUN -> no cnt_ena, prescaler frozen, expiry delayed by exactly 5 cycles.
REQ-040 Two expiries without irq_clr -> ovr=1; irq_clr same cycle as third expiry -> irq=1, ovr=0.
REQ-041 start and stop both high in RUN -> IDLE, shadows unchanged; start alone in RUN with reload=3 -> LOAD next cycle, cnt=3.
REQ-042 rst asserted mid-RUN with prescaler nonzero -> all outputs at REQ-035 values next cycle, no ev.

Source files
------------

// File: rtl/controlador_temporizador_32.sv
// Timer controller for an external 32-bit up/down counter: prescaled ticks,
// one-shot or periodic expiry, event pulse and sticky irq/overrun flags.
module controlador_temporizador_32 #(
    parameter int PRE_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             hold,
    input  logic             mode,
    input  logic             dir,
    input  logic [31:0]      reload,
    input  logic [PRE_W-1:0] presc,
    input  logic             irq_clr,
    input  logic             cnt_tc,
    output logic             cnt_ena,
    output logic             cnt_load,
    output logic             cnt_up,
    output logic [31:0]      cnt_d,
    output logic             busy,
    output logic             ev,
    output logic             irq,
    output logic             ovr
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [PRE_W-1:0] pre_reg, pre_next;
    logic [PRE_W-1:0] presc_reg;
    logic [31:0]      reload_reg;
    logic             mode_reg, dir_reg;
    logic             ev_reg, irq_reg, ovr_reg;
    logic             tick, expiry;

    always_comb begin
        tick   = (state_reg == RUN) && (pre_reg == presc_reg);
        expiry = tick && !hold && cnt_tc;
    end

    // Next state: stop beats start, start beats the normal flow.
    always_comb begin
        state_next = state_reg;
        if (stop) begin
            state_next = IDLE;
        end else if (start) begin
            state_next = LOAD;
        end else begin
            case (state_reg)
                IDLE:    state_next = IDLE;
                LOAD:    state_next = RUN;
                RUN:     if (expiry) state_next = mode_reg ? LOAD : IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        pre_next = pre_reg;
        if (state_reg == LOAD) begin
            pre_next = '0;
        end else if (state_reg == RUN && !hold) begin
            pre_next = tick ? '0 : pre_reg + PRE_W'(1);
        end
    end

    always_comb begin
        cnt_load = (state_reg == LOAD);
        cnt_ena  = (state_reg == LOAD) || (tick && !hold);
        busy     = (state_reg != IDLE);
        cnt_up   = dir_reg;
        cnt_d    = reload_reg;
        ev       = ev_reg;
        irq      = irq_reg;
        ovr      = ovr_reg;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            pre_reg    <= '0;
            presc_reg  <= '0;
            reload_reg <= '0;
            mode_reg   <= 1'b0;
            dir_reg    <= 1'b1;
        end else begin
            state_reg <= state_next;
            pre_reg   <= pre_next;
            if (start && !stop) begin
                presc_reg  <= presc;
                reload_reg <= reload;
                mode_reg   <= mode;
                dir_reg    <= dir;
            end
        end
    end

    // A fresh expiry outranks irq_clr: irq stays set and overrun is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            ev_reg  <= 1'b0;
            irq_reg <= 1'b0;
            ovr_reg <= 1'b0;
        end else begin
            ev_reg <= expiry;
            if (expiry) begin
                irq_reg <= 1'b1;
                ovr_reg <= irq_clr ? 1'b0 : (ovr_reg || irq_reg);
            end else if (irq_clr) begin
                irq_reg <= 1'b0;
                ovr_reg <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_controlador_temporizador_32.sv
// Directed bench: timer controller paired with a behavioural 0..9 up/down counter.
module tb_controlador_temporizador_32;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0, stop = 1'b0, hold = 1'b0, mode = 1'b0, dir = 1'b0;
    logic [31:0] reload = '0;
    logic [15:0] presc = '0;
    logic        irq_clr = 1'b0;
    logic        cnt_tc;
    logic        cnt_ena, cnt_load, cnt_up, busy, ev, irq, ovr;
    logic [31:0] cnt_d;
    logic [31:0] cnt;

    int compares = 0;
    int errors   = 0;

    always #5 clk = ~clk;

    controlador_temporizador_32 #(.PRE_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .hold(hold),
        .mode(mode), .dir(dir), .reload(reload), .presc(presc),
        .irq_clr(irq_clr), .cnt_tc(cnt_tc), .cnt_ena(cnt_ena),
        .cnt_load(cnt_load), .cnt_up(cnt_up), .cnt_d(cnt_d), .busy(busy),
        .ev(ev), .irq(irq), .ovr(ovr)
    );

    // Downstream counter, range 0..9, terminal count qualified by enable.
    assign cnt_tc = cnt_ena && (cnt_up ? (cnt == 32'd9) : (cnt == 32'd0));
    always_ff @(posedge clk) begin
        if (rst) cnt <= '0;
        else if (cnt_ena) begin
            if (cnt_load)    cnt <= cnt_d;
            else if (cnt_up) cnt <= (cnt == 32'd9) ? 32'd0 : cnt + 32'd1;
            else             cnt <= (cnt == 32'd0) ? 32'd9 : cnt - 32'd1;
        end
    end

    task automatic tick_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick_clk();
        tick_clk();
        $display("test_reset: reset applied");
        compares++; if (cnt_ena !== 1'b0) begin errors++; $display("FAIL rst_cnt_ena: got %b want 0", cnt_ena); end
        compares++; if (cnt_load !== 1'b0) begin errors++; $display("FAIL rst_cnt_load: got %b want 0", cnt_load); end
        compares++; if (cnt_up !== 1'b1) begin errors++; $display("FAIL rst_cnt_up: got %b want 1", cnt_up); end
        compares++; if (cnt_d !== 32'd0) begin errors++; $display("FAIL rst_cnt_d: got %0d want 0", cnt_d); end
        compares++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
        compares++; if ({ev, irq, ovr} !== 3'b000) begin errors++; $display("FAIL rst_flags: got %b want 000", {ev, irq, ovr}); end
        rst = 1'b0;
        tick_clk();
    endtask

    // Periodic up, reload 7, presc 0: expiries every 4 cycles, ovr on the
    // second, irq_clr coinciding with the third.
    task automatic test_periodic();
        logic [31:0] exp_cnt;
        mode = 1'b1; dir = 1'b1; reload = 32'd7; presc = 16'd0; start = 1'b1;
        $display("test_periodic: start periodic up reload=7 presc=0");
        for (int c = 1; c <= 13; c++) begin
            tick_clk();
            start = 1'b0;
            irq_clr = (c == 12);
            if (c == 1) begin
                compares++; if (cnt_load !== 1'b1) begin errors++; $display("FAIL per_load c1: got %b want 1", cnt_load); end
                compares++; if (cnt_d !== 32'd7) begin errors++; $display("FAIL per_cnt_d c1: got %0d want 7", cnt_d); end
            end
            if (c >= 2) begin
                case ((c - 2) % 4)
                    0:       exp_cnt = 32'd7;
                    1:       exp_cnt = 32'd8;
                    2:       exp_cnt = 32'd9;
                    default: exp_cnt = 32'd0;
                endcase
                compares++; if (cnt !== exp_cnt) begin errors++; $display("FAIL per_cnt c%0d: got %0d want %0d", c, cnt, exp_cnt); end
                compares++; if (ev !== (c == 5 || c == 9 || c == 13)) begin errors++; $display("FAIL per_ev c%0d: got %b want %b", c, ev, (c == 5 || c == 9 || c == 13)); end
            end
            if (c == 5) begin
                compares++; if ({irq, ovr} !== 2'b10) begin errors++; $display("FAIL per_irq c5: got %b want 10", {irq, ovr}); end
            end
            if (c == 9) begin
                compares++; if ({irq, ovr} !== 2'b11) begin errors++; $display("FAIL per_ovr c9: got %b want 11", {irq, ovr}); end
            end
            if (c == 13) begin
                compares++; if ({irq, ovr} !== 2'b10) begin errors++; $display("FAIL per_clr_vs_exp c13: got %b want 10", {irq, ovr}); end
            end
        end
        irq_clr = 1'b1; stop = 1'b1;
        tick_clk();
        irq_clr = 1'b0; stop = 1'b0;
        compares++; if ({irq, ovr, busy} !== 3'b000) begin errors++; $display("FAIL per_stop_clr: got %b want 000", {irq, ovr, busy}); end
        compares++; if (cnt !== 32'd7) begin errors++; $display("FAIL per_cnt_held: got %0d want 7", cnt); end
    endtask

    // One-shot down, reload 2, presc 2: ticks every third RUN cycle.
    task automatic test_oneshot();
        mode = 1'b0; dir = 1'b0; reload = 32'd2; presc = 16'd2; start = 1'b1;
        $display("test_oneshot: start one-shot down reload=2 presc=2");
        for (int c = 1; c <= 12; c++) begin
            tick_clk();
            start = 1'b0;
            if (c >= 2 && c <= 10) begin
                compares++; if (cnt_ena !== (c == 4 || c == 7 || c == 10)) begin errors++; $display("FAIL os_ena c%0d: got %b want %b", c, cnt_ena, (c == 4 || c == 7 || c == 10)); end
            end
            if (c >= 2) begin
                compares++; if (ev !== (c == 11)) begin errors++; $display("FAIL os_ev c%0d: got %b want %b", c, ev, (c == 11)); end
            end
            if (c == 2) begin
                compares++; if (cnt_up !== 1'b0) begin errors++; $display("FAIL os_cnt_up: got %b want 0", cnt_up); end
            end
            if (c == 8) begin
                compares++; if (cnt !== 32'd0) begin errors++; $display("FAIL os_cnt c8: got %0d want 0", cnt); end
            end
            if (c == 11) begin
                compares++; if ({busy, irq, ovr} !== 3'b010) begin errors++; $display("FAIL os_flags c11: got %b want 010", {busy, irq, ovr}); end
            end
            if (c == 12) begin
                compares++; if (cnt !== 32'd9) begin errors++; $display("FAIL os_cnt_wrapped: got %0d want 9", cnt); end
                compares++; if (busy !== 1'b0) begin errors++; $display("FAIL os_busy c12: got %b want 0", busy); end
            end
        end
        irq_clr = 1'b1;
        tick_clk();
        irq_clr = 1'b0;
    endtask

    // One-shot up, reload 5, presc 1; hold during cycles 6..10 shifts expiry by 5.
    task automatic test_hold();
        logic exp_ena;
        mode = 1'b0; dir = 1'b1; reload = 32'd5; presc = 16'd1; start = 1'b1;
        $display("test_hold: start one-shot up reload=5 presc=1 with 5-cycle hold");
        for (int c = 1; c <= 18; c++) begin
            tick_clk();
            start = 1'b0;
            hold = (c >= 6 && c <= 10);
            exp_ena = (c == 3 || c == 5 || c == 12 || c == 14 || c == 16);
            if (c >= 2 && c <= 16) begin
                compares++; if (cnt_ena !== exp_ena) begin errors++; $display("FAIL hold_ena c%0d: got %b want %b", c, cnt_ena, exp_ena); end
            end
            if (c >= 2) begin
                compares++; if (ev !== (c == 17)) begin errors++; $display("FAIL hold_ev c%0d: got %b want %b", c, ev, (c == 17)); end
            end
            if (c == 8) begin
                compares++; if (cnt !== 32'd7) begin errors++; $display("FAIL hold_cnt c8: got %0d want 7", cnt); end
            end
            if (c == 18) begin
                compares++; if ({busy, irq} !== 2'b01) begin errors++; $display("FAIL hold_end: got %b want 01", {busy, irq}); end
            end
        end
        hold = 1'b0;
    endtask

    task automatic test_start_stop();
        mode = 1'b1; dir = 1'b1; reload = 32'd4; presc = 16'd3; start = 1'b1;
        $display("test_start_stop: start periodic up reload=4, then start+stop");
        for (int c = 1; c <= 4; c++) begin
            tick_clk();
            start = 1'b0;
        end
        start = 1'b1; stop = 1'b1; reload = 32'd8; dir = 1'b0; mode = 1'b0; presc = 16'd0;
        tick_clk();
        start = 1'b0; stop = 1'b0;
        compares++; if ({busy, cnt_ena} !== 2'b00) begin errors++; $display("FAIL ss_idle: got %b want 00", {busy, cnt_ena}); end
        compares++; if (cnt_d !== 32'd4) begin errors++; $display("FAIL ss_cnt_d: got %0d want 4", cnt_d); end
        compares++; if (cnt_up !== 1'b1) begin errors++; $display("FAIL ss_cnt_up: got %b want 1", cnt_up); end

        mode = 1'b1; dir = 1'b1; reload = 32'd4; presc = 16'd3; start = 1'b1;
        $display("test_start_stop: start reload=4, restart in RUN with reload=3");
        tick_clk();
        start = 1'b0;
        tick_clk();
        tick_clk();
        start = 1'b1; reload = 32'd3;
        tick_clk();
        start = 1'b0;
        compares++; if (cnt_load !== 1'b1) begin errors++; $display("FAIL ss_restart_load: got %b want 1", cnt_load); end
        compares++; if (cnt_d !== 32'd3) begin errors++; $display("FAIL ss_restart_d: got %0d want 3", cnt_d); end
        tick_clk();
        compares++; if (cnt !== 32'd3) begin errors++; $display("FAIL ss_restart_cnt: got %0d want 3", cnt); end
        compares++; if (busy !== 1'b1) begin errors++; $display("FAIL ss_restart_busy: got %b want 1", busy); end
        stop = 1'b1;
        tick_clk();
        stop = 1'b0;
    endtask

    task automatic test_reset_midrun();
        mode = 1'b1; dir = 1'b0; reload = 32'd6; presc = 16'd5; start = 1'b1;
        $display("test_reset_midrun: start periodic down reload=6 presc=5, reset in RUN");
        for (int c = 1; c <= 4; c++) begin
            tick_clk();
            start = 1'b0;
        end
        rst = 1'b1;
        tick_clk();
        rst = 1'b0;
        compares++; if ({cnt_ena, cnt_load, cnt_up} !== 3'b001) begin errors++; $display("FAIL mid_rst_ctl: got %b want 001", {cnt_ena, cnt_load, cnt_up}); end
        compares++; if (cnt_d !== 32'd0) begin errors++; $display("FAIL mid_rst_cnt_d: got %0d want 0", cnt_d); end
        compares++; if ({busy, ev, irq, ovr} !== 4'b0000) begin errors++; $display("FAIL mid_rst_flags: got %b want 0000", {busy, ev, irq, ovr}); end
        tick_clk();
        compares++; if ({busy, ev} !== 2'b00) begin errors++; $display("FAIL mid_rst_after: got %b want 00", {busy, ev}); end
    endtask

    initial begin
        test_reset();
        test_periodic();
        test_oneshot();
        test_hold();
        test_start_stop();
        test_reset_midrun();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, errors);
        $finish;
    end

endmodule
